mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single fixed-latency main-memory port between the instruction-cache refill path and the data-cache refill/writeback path. Requests are granted round-robin, issued to memory one at a time, and the response is routed back to the owner. The block sits between both caches' miss handlers and the memory model. Caches stall on their miss signal until `*_resp_valid` is asserted.

Parameters:
- ADDR_BITS, 32, physical address width (`XLEN`)
- LINE_BITS, 128, cache line width in bits
- MEM_LATENCY, 5, cycles from the `mem_req_valid` cycle to valid `mem_rdata`; must be ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ic_req_valid  in  1  icache line-fill request
- ic_req_addr  in  ADDR_BITS  line address
- ic_req_ready  out  1  request accepted this cycle
- ic_resp_valid  out  1  one-cycle fill-done pulse
- ic_resp_data  out  LINE_BITS  fill data
- dc_req_valid  in  1  dcache request
- dc_req_write  in  1  1 = writeback, 0 = fill
- dc_req_addr  in  ADDR_BITS  line address
- dc_req_wdata  in  LINE_BITS  writeback data
- dc_req_ready  out  1  request accepted this cycle
- dc_resp_valid  out  1  one-cycle done pulse (fill or write)
- dc_resp_data  out  LINE_BITS  fill data; 0 on writes
- mem_req_valid  out  1  one-cycle issue pulse
- mem_req_write  out  1  write strobe
- mem_req_addr  out  ADDR_BITS  issued address
- mem_req_wdata  out  LINE_BITS  issued write data
- mem_rdata  in  LINE_BITS  read data, valid exactly MEM_LATENCY cycles after issue

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0, counter 0, `last_grant` = ICACHE (so the dcache wins the first tie).
- IDLE:
  - Combinational pick. If only one requester is valid, pick it. If both are valid, pick the one that is not `last_grant`.
  - Assert the picked `*_req_ready` in the same cycle (Mealy).
  - On valid&ready: latch owner, write, addr and wdata; go to ISSUE.
  - Ready is never asserted outside IDLE.
- ISSUE:
  - Assert `mem_req_valid`=1 for exactly one cycle.
  - `mem_req_*` outputs are driven from the latched registers and held stable in every non-IDLE state.
  - Load counter = MEM_LATENCY-1; go to WAIT.
- WAIT:
  - When counter==0: capture `mem_rdata` into the response register (write → capture 0) and go to RESP.
  - Otherwise decrement the counter.
  - With MEM_LATENCY=1, WAIT lasts exactly one cycle.
- RESP:
  - Pulse the owner's `*_resp_valid` for one cycle, with `*_resp_data` from the register.
  - The non-owner's resp_valid stays 0; resp_data is 0 whenever resp_valid=0.
  - `last_grant` ← owner; go to IDLE.
- Latency: accept at cycle T → `mem_req_valid` at T+1 → data sampled at T+1+MEM_LATENCY → resp_valid at T+2+MEM_LATENCY.
- Minimum spacing between accepts is MEM_LATENCY+3 cycles; there is no pipelining.
- Requester contract: hold valid and payload stable until ready. A requester must not reissue before its own resp_valid; the bench asserts both rules.
- Simultaneous events:
  - A new request arriving during ISSUE/WAIT/RESP waits with no ready.
  - A request arriving in the RESP cycle is considered in the next IDLE, under the updated `last_grant`.
- Counter width is `$clog2(MEM_LATENCY+1)`; no wrap is possible.
- Reset mid-transaction (rst_n low in any state):
  - Immediately return to IDLE and clear all outputs.
  - The in-flight memory result is discarded; no resp_valid is ever produced for it.
  - Requesters are reset by the same rst_n.

Decomposition:
- Shared package (mem_pkg):
  - `arb_owner_e` {OWNER_IC, OWNER_DC}
  - `arb_state_e`
  - `mem_req_t` struct {write, addr, wdata}
  - MEM_LATENCY default constant alongside `OPCODE_*`/`ILEN` in const.svh
- One sub-module: `rr_pick2`, a combinational 2-way round-robin picker (inputs: req[1:0], last_grant; output: grant one-hot). Reused later for a multi-port memory.

Test Plan:
- Single icache fill, MEM_LATENCY=5, `ic_req_addr`=0x0000_1000 accepted at cycle 10 → `mem_req_valid` at cycle 11 with addr 0x1000, write=0. Memory drives 128'hA5…A5 at cycle 16 → `ic_resp_valid` at cycle 17 with that data; `dc_resp_valid` stays 0 throughout.
- Both requesters valid at the first IDLE after reset → dc granted first. The ic request is accepted in the next IDLE, exactly 8 cycles after the dc accept; alternation holds over 4 back-to-back pairs.
- dc writeback, addr 0x2000, wdata 128'h1234… → one `mem_req_valid` with write=1 and matching data/addr; `dc_resp_valid` pulse with `dc_resp_data`=0.
- ic request raised in the dc RESP cycle while dc also re-requests in IDLE → ic wins, because `last_grant`=DC.
- rst_n asserted in WAIT with counter=2 → all outputs 0 within the same cycle, FSM in IDLE, no resp_valid after release. A fresh request then completes normally.
- MEM_LATENCY=1 build → accept at T, issue at T+1, resp at T+3.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the main-memory arbiter and its round-robin picker.
package mem_pkg;
   localparam int MEM_ADDR_BITS    = 32;
   localparam int MEM_LINE_BITS    = 128;
   localparam int MEM_LATENCY_DFLT = 5;

   typedef enum logic {OWNER_IC = 1'b0, OWNER_DC = 1'b1} arb_owner_e;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

   // Request latch; sized to the package-wide widths that the arbiter ports default to.
   typedef struct packed {
      logic                     write;
      logic [MEM_ADDR_BITS-1:0] addr;
      logic [MEM_LINE_BITS-1:0] wdata;
   } mem_req_t;
endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; grant bit index equals the arb_owner_e encoding.
module rr_pick2
   import mem_pkg::*;
(
   input  logic [1:0] req,
   input  arb_owner_e last_grant,
   output logic [1:0] grant
);
   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == OWNER_IC) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between icache refills and dcache refill/writeback,
// one transaction at a time, granted round-robin.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_BITS   = MEM_ADDR_BITS,
   parameter int LINE_BITS   = MEM_LINE_BITS,
   parameter int MEM_LATENCY = MEM_LATENCY_DFLT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ic_req_valid,
   input  logic [ADDR_BITS-1:0] ic_req_addr,
   output logic                 ic_req_ready,
   output logic                 ic_resp_valid,
   output logic [LINE_BITS-1:0] ic_resp_data,
   input  logic                 dc_req_valid,
   input  logic                 dc_req_write,
   input  logic [ADDR_BITS-1:0] dc_req_addr,
   input  logic [LINE_BITS-1:0] dc_req_wdata,
   output logic                 dc_req_ready,
   output logic                 dc_resp_valid,
   output logic [LINE_BITS-1:0] dc_resp_data,
   output logic                 mem_req_valid,
   output logic                 mem_req_write,
   output logic [ADDR_BITS-1:0] mem_req_addr,
   output logic [LINE_BITS-1:0] mem_req_wdata,
   input  logic [LINE_BITS-1:0] mem_rdata
);
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   arb_state_e           state, state_nxt;
   arb_owner_e           owner, last_grant;
   mem_req_t             req_q;
   logic [CNT_W-1:0]     cnt;
   logic [LINE_BITS-1:0] resp_q;
   logic [1:0]           grant;

   rr_pick2 u_pick (
      .req        ({dc_req_valid, ic_req_valid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_comb begin
      state_nxt    = state;
      ic_req_ready = 1'b0;
      dc_req_ready = 1'b0;
      case (state)
         IDLE: begin
            ic_req_ready = grant[0];
            dc_req_ready = grant[1];
            if (|grant) state_nxt = ISSUE;
         end
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= OWNER_IC;
         last_grant <= OWNER_IC;
         req_q      <= '0;
         cnt        <= '0;
         resp_q     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant[1]) begin
                  owner       <= OWNER_DC;
                  req_q.write <= dc_req_write;
                  req_q.addr  <= dc_req_addr;
                  req_q.wdata <= dc_req_wdata;
               end else if (grant[0]) begin
                  owner       <= OWNER_IC;
                  req_q.write <= 1'b0;
                  req_q.addr  <= ic_req_addr;
                  req_q.wdata <= '0;
               end
            end
            ISSUE: cnt <= CNT_W'(MEM_LATENCY - 1);
            WAIT: begin
               // Writes report zero data back to the dcache.
               if (cnt == '0) resp_q <= req_q.write ? '0 : mem_rdata;
               else           cnt    <= cnt - 1'b1;
            end
            RESP:    last_grant <= owner;
            default: ;
         endcase
      end
   end

   assign mem_req_valid = (state == ISSUE);
   assign mem_req_write = req_q.write;
   assign mem_req_addr  = req_q.addr;
   assign mem_req_wdata = req_q.wdata;

   assign ic_resp_valid = (state == RESP) && (owner == OWNER_IC);
   assign dc_resp_valid = (state == RESP) && (owner == OWNER_DC);
   assign ic_resp_data  = ic_resp_valid ? resp_q : '0;
   assign dc_resp_data  = dc_resp_valid ? resp_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timestamp-based reference model, vector table, directed corner cases.
module tb_mem_arbiter;
   import mem_pkg::*;
   localparam int AW = 32, LW = 128, LAT = 5;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          ic_req_valid, ic_req_ready, ic_resp_valid;
   logic [AW-1:0] ic_req_addr;
   logic [LW-1:0] ic_resp_data;
   logic          dc_req_valid, dc_req_write, dc_req_ready, dc_resp_valid;
   logic [AW-1:0] dc_req_addr;
   logic [LW-1:0] dc_req_wdata, dc_resp_data;
   logic          mem_req_valid, mem_req_write;
   logic [AW-1:0] mem_req_addr;
   logic [LW-1:0] mem_req_wdata, mem_rdata;

   mem_arbiter #(.ADDR_BITS(AW), .LINE_BITS(LW), .MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
      .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_rdata(mem_rdata)
   );

   // Single-cycle-latency build, exercised with a short directed sequence.
   logic          a_ic_req_valid, a_ic_req_ready, a_ic_resp_valid;
   logic [AW-1:0] a_ic_req_addr;
   logic [LW-1:0] a_ic_resp_data;
   logic          a_dc_req_valid, a_dc_req_write, a_dc_req_ready, a_dc_resp_valid;
   logic [AW-1:0] a_dc_req_addr;
   logic [LW-1:0] a_dc_req_wdata, a_dc_resp_data;
   logic          a_mem_req_valid, a_mem_req_write;
   logic [AW-1:0] a_mem_req_addr;
   logic [LW-1:0] a_mem_req_wdata, a_mem_rdata;

   mem_arbiter #(.ADDR_BITS(AW), .LINE_BITS(LW), .MEM_LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .ic_req_valid(a_ic_req_valid), .ic_req_addr(a_ic_req_addr), .ic_req_ready(a_ic_req_ready),
      .ic_resp_valid(a_ic_resp_valid), .ic_resp_data(a_ic_resp_data),
      .dc_req_valid(a_dc_req_valid), .dc_req_write(a_dc_req_write), .dc_req_addr(a_dc_req_addr),
      .dc_req_wdata(a_dc_req_wdata), .dc_req_ready(a_dc_req_ready),
      .dc_resp_valid(a_dc_resp_valid), .dc_resp_data(a_dc_resp_data),
      .mem_req_valid(a_mem_req_valid), .mem_req_write(a_mem_req_write), .mem_req_addr(a_mem_req_addr),
      .mem_req_wdata(a_mem_req_wdata), .mem_rdata(a_mem_rdata)
   );

   int n_pass = 0, n_tot = 0;
   task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [LW-1:0] mem_word(logic [AW-1:0] a);
      return {a, ~a, a ^ 32'hA5A5_A5A5, a + 32'h1357_9BDF};
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: correct line only on the cycle it is due, noise otherwise.
   int            mem_due = -1;
   logic [AW-1:0] mem_addr;
   always @(posedge clk) begin
      #1;
      mem_rdata = (cyc == mem_due) ? mem_word(mem_addr) : {4{$urandom}};
   end

   // Reference model: arbiter free from m_free; one transaction occupies LAT+3 cycles.
   int            m_free = 0, e_iss = -1, e_rsp = -1;
   bit            m_last, e_own, e_w;
   logic [AW-1:0] e_addr;
   logic [LW-1:0] e_wd;
   bit            ic_acc_now, dc_acc_now, ic_rsp_now, dc_rsp_now, mon_ic_out, mon_dc_out;
   bit            prev_ic_v, prev_ic_r, prev_dc_v, prev_dc_r;
   logic [AW-1:0] prev_ic_a, prev_dc_a;
   int            acc_own_q[$], acc_cyc_q[$], iss_cyc_q[$], rsp_own_q[$], rsp_cyc_q[$];
   bit            iss_w_q[$];
   logic [AW-1:0] iss_addr_q[$];
   logic [LW-1:0] iss_wd_q[$], rsp_data_q[$];
   int            dc_rsp_total = 0;

   always @(negedge clk) begin
      bit pk_dc, x_ic_r, x_dc_r, x_mv, x_icv, x_dcv;
      logic [LW-1:0] x_data;
      ic_acc_now = 0; dc_acc_now = 0; ic_rsp_now = 0; dc_rsp_now = 0;
      if (!rst_n) begin
         chk("reset_outputs", LW'(|{ic_req_ready, ic_resp_valid, ic_resp_data, dc_req_ready,
             dc_resp_valid, dc_resp_data, mem_req_valid, mem_req_write, mem_req_addr,
             mem_req_wdata}), '0);
         m_free = 0; m_last = 0; e_iss = -1; e_rsp = -1; mem_due = -1;
         mon_ic_out = 0; mon_dc_out = 0; prev_ic_v = 0; prev_dc_v = 0;
      end else begin
         if (prev_ic_v && !prev_ic_r)
            assert (ic_req_valid && ic_req_addr == prev_ic_a) else $error("ic dropped request before ready");
         if (prev_dc_v && !prev_dc_r)
            assert (dc_req_valid && dc_req_addr == prev_dc_a) else $error("dc dropped request before ready");
         assert (!(ic_req_valid && mon_ic_out)) else $error("ic reissued before its response");
         assert (!(dc_req_valid && mon_dc_out)) else $error("dc reissued before its response");

         pk_dc  = dc_req_valid && (!ic_req_valid || m_last == 1'b0);
         x_dc_r = (cyc >= m_free) && pk_dc;
         x_ic_r = (cyc >= m_free) && ic_req_valid && !pk_dc;
         chk("ic_req_ready", LW'(ic_req_ready), LW'(x_ic_r));
         chk("dc_req_ready", LW'(dc_req_ready), LW'(x_dc_r));
         x_mv = (cyc == e_iss);
         chk("mem_req_valid", LW'(mem_req_valid), LW'(x_mv));
         if (x_mv) begin
            chk("mem_req_write", LW'(mem_req_write), LW'(e_w));
            chk("mem_req_addr", LW'(mem_req_addr), LW'(e_addr));
            if (e_w) chk("mem_req_wdata", mem_req_wdata, e_wd);
         end
         x_icv  = (cyc == e_rsp) && !e_own;
         x_dcv  = (cyc == e_rsp) && e_own;
         x_data = e_w ? '0 : mem_word(e_addr);
         chk("ic_resp_valid", LW'(ic_resp_valid), LW'(x_icv));
         chk("dc_resp_valid", LW'(dc_resp_valid), LW'(x_dcv));
         chk("ic_resp_data", ic_resp_data, x_icv ? x_data : '0);
         chk("dc_resp_data", dc_resp_data, x_dcv ? x_data : '0);
         if (x_dc_r || x_ic_r) begin
            e_own  = x_dc_r;
            e_w    = x_dc_r ? dc_req_write : 1'b0;
            e_addr = x_dc_r ? dc_req_addr : ic_req_addr;
            e_wd   = x_dc_r ? dc_req_wdata : '0;
            e_iss  = cyc + 1;
            e_rsp  = cyc + 2 + LAT;
            m_free = cyc + LAT + 3;
            m_last = e_own;
         end

         ic_acc_now = ic_req_valid && ic_req_ready;
         dc_acc_now = dc_req_valid && dc_req_ready;
         if (ic_acc_now) begin acc_own_q.push_back(0); acc_cyc_q.push_back(cyc); mon_ic_out = 1; end
         if (dc_acc_now) begin acc_own_q.push_back(1); acc_cyc_q.push_back(cyc); mon_dc_out = 1; end
         if (mem_req_valid) begin
            iss_cyc_q.push_back(cyc); iss_addr_q.push_back(mem_req_addr);
            iss_w_q.push_back(mem_req_write); iss_wd_q.push_back(mem_req_wdata);
            mem_due = cyc + LAT; mem_addr = mem_req_addr;
         end
         if (ic_resp_valid) begin
            ic_rsp_now = 1; mon_ic_out = 0;
            rsp_own_q.push_back(0); rsp_cyc_q.push_back(cyc); rsp_data_q.push_back(ic_resp_data);
         end
         if (dc_resp_valid) begin
            dc_rsp_now = 1; mon_dc_out = 0; dc_rsp_total++;
            rsp_own_q.push_back(1); rsp_cyc_q.push_back(cyc); rsp_data_q.push_back(dc_resp_data);
         end
         prev_ic_v = ic_req_valid; prev_ic_r = ic_req_ready; prev_ic_a = ic_req_addr;
         prev_dc_v = dc_req_valid; prev_dc_r = dc_req_ready; prev_dc_a = dc_req_addr;
      end
   end

   // Requesters: drop valid after accept, stay quiet until the response, then maybe re-request.
   bit ic_out, dc_out;
   task automatic step_reqs(int rate);
      if (ic_rsp_now) ic_out = 0;
      if (dc_rsp_now) dc_out = 0;
      if (ic_req_valid && ic_acc_now) begin ic_req_valid = 0; ic_out = 1; end
      if (dc_req_valid && dc_acc_now) begin dc_req_valid = 0; dc_out = 1; end
      if (!ic_req_valid && !ic_out && rate > 0 && int'($urandom_range(99)) < rate) begin
         ic_req_valid = 1; ic_req_addr = $urandom & ~32'hF;
      end
      if (!dc_req_valid && !dc_out && rate > 0 && int'($urandom_range(99)) < rate) begin
         dc_req_valid = 1; dc_req_write = $urandom_range(1); dc_req_addr = $urandom & ~32'hF;
         dc_req_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic tick(int rate = 0);
      @(posedge clk); #1; step_reqs(rate);
   endtask

   task automatic goto(int c);
      while (cyc < c) tick();
   endtask

   task automatic wait_rsp(int target, string name);
      for (int k = 0; k < 200 && rsp_data_q.size() < target; k++) tick();
      chk({name, "_rsp_timeout"}, LW'(rsp_data_q.size() >= target), LW'(1));
   endtask

   task automatic wait_acc(int target, string name);
      for (int k = 0; k < 100 && acc_own_q.size() < target; k++) tick();
      chk({name, "_acc_timeout"}, LW'(acc_own_q.size() >= target), LW'(1));
   endtask

   task automatic drain(string name);
      for (int k = 0; k < 200 && (ic_req_valid || dc_req_valid || ic_out || dc_out); k++) tick();
      chk({name, "_drain_timeout"}, LW'(ic_req_valid || dc_req_valid || ic_out || dc_out), '0);
   endtask

   typedef struct {
      bit            ic_v;
      logic [AW-1:0] ic_a;
      bit            dc_v, dc_w;
      logic [AW-1:0] dc_a;
      logic [LW-1:0] dc_wd;
      int            x_own;
      bit            x_w;
      logic [AW-1:0] x_a;
      logic [LW-1:0] x_wd, x_rd;
   } vec_t;
   vec_t tbl[6];

   initial begin
      int b, br, t;
      logic [LW-1:0] wd0, wd1, magic;
      wd0   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
      wd1   = 128'hCAFE_F00D_DEAD_BEEF_0123_4567_89AB_CDEF;
      magic = 128'h5A5A_0001_5A5A_0002_5A5A_0003_5A5A_0004;
      // ic-only / dc-only / both; expected owner follows from the running last grant (starts IC).
      tbl[0] = '{0, 0,          1, 1, 32'h2000, wd0, 1, 1, 32'h2000, wd0, '0};
      tbl[1] = '{1, 32'h3000,   1, 0, 32'h4000, '0,  0, 0, 32'h3000, '0,  mem_word(32'h3000)};
      tbl[2] = '{1, 32'h5000,   1, 1, 32'h6000, wd1, 0, 0, 32'h5000, '0,  mem_word(32'h5000)};
      tbl[3] = '{1, 32'h7000,   0, 0, 0,        '0,  0, 0, 32'h7000, '0,  mem_word(32'h7000)};
      tbl[4] = '{1, 32'h8000,   1, 0, 32'h9000, '0,  1, 0, 32'h9000, '0,  mem_word(32'h9000)};
      tbl[5] = '{0, 0,          1, 0, 32'hA000, '0,  1, 0, 32'hA000, '0,  mem_word(32'hA000)};

      ic_req_valid = 0; ic_req_addr = '0; dc_req_valid = 0; dc_req_write = 0;
      dc_req_addr = '0; dc_req_wdata = '0;
      a_ic_req_valid = 0; a_ic_req_addr = '0; a_dc_req_valid = 0; a_dc_req_write = 0;
      a_dc_req_addr = '0; a_dc_req_wdata = '0; a_mem_rdata = '1;

      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // Single icache fill accepted at cycle 10.
      b = acc_own_q.size(); br = rsp_data_q.size();
      goto(10);
      ic_req_valid = 1; ic_req_addr = 32'h0000_1000;
      wait_rsp(br + 1, "t1");
      chk("t1_acc_cycle", LW'(acc_cyc_q[b]), LW'(10));
      chk("t1_acc_owner", LW'(acc_own_q[b]), LW'(0));
      chk("t1_issue_cycle", LW'(iss_cyc_q[b]), LW'(11));
      chk("t1_issue_addr", LW'(iss_addr_q[b]), LW'(32'h1000));
      chk("t1_issue_write", LW'(iss_w_q[b]), '0);
      chk("t1_resp_cycle", LW'(rsp_cyc_q[br]), LW'(17));
      chk("t1_resp_owner", LW'(rsp_own_q[br]), LW'(0));
      chk("t1_resp_data", rsp_data_q[br], mem_word(32'h1000));
      chk("t1_no_dc_resp", LW'(dc_rsp_total), '0);

      foreach (tbl[i]) begin
         tick(); tick();
         b = acc_own_q.size(); br = rsp_data_q.size();
         ic_req_valid = tbl[i].ic_v; ic_req_addr = tbl[i].ic_a;
         dc_req_valid = tbl[i].dc_v; dc_req_write = tbl[i].dc_w;
         dc_req_addr  = tbl[i].dc_a; dc_req_wdata = tbl[i].dc_wd;
         wait_rsp(br + int'(tbl[i].ic_v) + int'(tbl[i].dc_v), $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_owner", i), LW'(acc_own_q[b]), LW'(tbl[i].x_own));
         chk($sformatf("vec%0d_addr", i), LW'(iss_addr_q[b]), LW'(tbl[i].x_a));
         chk($sformatf("vec%0d_write", i), LW'(iss_w_q[b]), LW'(tbl[i].x_w));
         if (tbl[i].x_w) chk($sformatf("vec%0d_wdata", i), iss_wd_q[b], tbl[i].x_wd);
         chk($sformatf("vec%0d_resp_owner", i), LW'(rsp_own_q[br]), LW'(tbl[i].x_own));
         chk($sformatf("vec%0d_resp_data", i), rsp_data_q[br], tbl[i].x_rd);
      end

      // ic raised during the dc RESP cycle beats the dc re-request in the next IDLE.
      tick(); tick();
      b = acc_own_q.size(); br = rsp_data_q.size();
      dc_req_valid = 1; dc_req_write = 0; dc_req_addr = 32'hB000;
      wait_acc(b + 1, "t4");
      t = acc_cyc_q[b];
      goto(t + 7);
      ic_req_valid = 1; ic_req_addr = 32'hC000;
      tick();
      dc_req_valid = 1; dc_req_write = 0; dc_req_addr = 32'hD000;
      wait_rsp(br + 3, "t4");
      chk("t4_ic_wins", LW'(acc_own_q[b + 1]), LW'(0));
      chk("t4_ic_acc_cycle", LW'(acc_cyc_q[b + 1]), LW'(t + 8));
      chk("t4_dc_after", LW'(acc_own_q[b + 2]), LW'(1));

      // Reset while WAIT holds counter==2: everything clears, the result is dropped.
      tick(); tick();
      b = acc_own_q.size();
      ic_req_valid = 1; ic_req_addr = 32'hE000;
      wait_acc(b + 1, "t5");
      t = acc_cyc_q[b];
      goto(t + 4);
      rst_n = 0; ic_req_valid = 0; dc_req_valid = 0; ic_out = 0; dc_out = 0;
      #1;
      chk("t5_outputs_cleared", LW'(|{ic_req_ready, ic_resp_valid, ic_resp_data, dc_req_ready,
          dc_resp_valid, dc_resp_data, mem_req_valid, mem_req_write, mem_req_addr,
          mem_req_wdata}), '0);
      tick(); tick();
      rst_n = 1;
      br = rsp_data_q.size();
      repeat (15) tick();
      chk("t5_no_stale_resp", LW'(rsp_data_q.size()), LW'(br));
      ic_req_valid = 1; ic_req_addr = 32'hF000;
      wait_rsp(br + 1, "t5_fresh");
      chk("t5_fresh_owner", LW'(rsp_own_q[br]), LW'(0));
      chk("t5_fresh_data", rsp_data_q[br], mem_word(32'hF000));

      // Both valid at the first IDLE after reset: dc first, then strict alternation every 8 cycles.
      drain("t2_pre");
      rst_n = 0;
      tick(); tick();
      @(posedge clk); #1;
      rst_n = 1;
      b = acc_own_q.size();
      step_reqs(100);
      repeat (80) tick(100);
      drain("t2");
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t2_owner%0d", i), LW'(acc_own_q[b + i]), LW'((i % 2 == 0) ? 1 : 0));
         if (i > 0)
            chk($sformatf("t2_spacing%0d", i), LW'(acc_cyc_q[b + i] - acc_cyc_q[b + i - 1]), LW'(8));
      end

      // Randomized traffic against the reference model.
      repeat (1500) tick(30);
      drain("rand");

      // MEM_LATENCY=1: accept at c, issue at c+1, data at c+2, response at c+3.
      tick();
      a_ic_req_valid = 1; a_ic_req_addr = 32'h40;
      @(negedge clk);
      chk("l1_ready", LW'(a_ic_req_ready), LW'(1));
      chk("l1_no_issue_yet", LW'(a_mem_req_valid), '0);
      @(posedge clk); #1 a_ic_req_valid = 0;
      @(negedge clk);
      chk("l1_issue", LW'(a_mem_req_valid), LW'(1));
      chk("l1_issue_addr", LW'(a_mem_req_addr), LW'(32'h40));
      @(posedge clk); #1 a_mem_rdata = magic;
      @(negedge clk);
      chk("l1_no_resp_yet", LW'(a_ic_resp_valid), '0);
      @(posedge clk); #1 a_mem_rdata = '1;
      @(negedge clk);
      chk("l1_resp", LW'(a_ic_resp_valid), LW'(1));
      chk("l1_resp_data", a_ic_resp_data, magic);
      @(negedge clk);
      chk("l1_resp_one_cycle", LW'(a_ic_resp_valid), '0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
      $fatal(1, "watchdog");
   end
endmodule
